// File: rtl/rop3_arbiter.sv
// Two-requester front end for a shared ROP3 core: per-beat round-robin with a bounded
// burst, a registered issue stage, and a tag pipeline that steers each result back to its owner.
module rop3_arbiter #(
  parameter int N         = 8,
  parameter int LAT       = 2,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_P,
  input  logic [N-1:0] req0_S,
  input  logic [N-1:0] req0_D,
  input  logic [7:0]   req0_mode,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_P,
  input  logic [N-1:0] req1_S,
  input  logic [N-1:0] req1_D,
  input  logic [7:0]   req1_mode,
  output logic         resp0_valid,
  output logic [N-1:0] resp0_result,
  output logic         resp1_valid,
  output logic [N-1:0] resp1_result,
  output logic [N-1:0] rop_P,
  output logic [N-1:0] rop_S,
  output logic [N-1:0] rop_D,
  output logic [7:0]   rop_mode,
  input  logic [N-1:0] rop_result,
  output logic         idle
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

  typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} owner_t;

  owner_t          owner;
  owner_t          fire_id;
  logic [CW-1:0]   burst_cnt;
  logic            grant0;
  logic            grant1;
  logic            fire0;
  logic            fire1;
  logic            fire;
  logic [LAT-1:0]  tag_v;
  logic [LAT-1:0]  tag_id;

  // On a tie the owner keeps the core until its burst allowance is used up.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (burst_cnt < BURST_MAX) begin
        grant0 = (owner == REQ0);
        grant1 = (owner == REQ1);
      end else begin
        grant0 = (owner == REQ1);
        grant1 = (owner == REQ0);
      end
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign fire0      = req0_valid & req0_ready;
  assign fire1      = req1_valid & req1_ready;
  assign fire       = fire0 | fire1;
  assign fire_id    = fire1 ? REQ1 : REQ0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner     <= REQ1;
      burst_cnt <= BURST_MAX;
    end else if (fire) begin
      if (fire_id == owner) begin
        if (burst_cnt < BURST_MAX) burst_cnt <= burst_cnt + CW'(1);
      end else begin
        owner     <= fire_id;
        burst_cnt <= CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rop_P    <= '0;
      rop_S    <= '0;
      rop_D    <= '0;
      rop_mode <= '0;
    end else if (fire) begin
      rop_P    <= fire1 ? req1_P    : req0_P;
      rop_S    <= fire1 ? req1_S    : req0_S;
      rop_D    <= fire1 ? req1_D    : req0_D;
      rop_mode <= fire1 ? req1_mode : req0_mode;
    end
  end

  // The last tag stage lines up with the core's output for the same beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
      tag_v[0]  <= fire;
      tag_id[0] <= fire1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp0_valid  <= 1'b0;
      resp1_valid  <= 1'b0;
      resp0_result <= '0;
      resp1_result <= '0;
    end else begin
      resp0_valid <= tag_v[LAT-1] & ~tag_id[LAT-1];
      resp1_valid <= tag_v[LAT-1] &  tag_id[LAT-1];
      if (tag_v[LAT-1] && !tag_id[LAT-1]) resp0_result <= rop_result;
      if (tag_v[LAT-1] &&  tag_id[LAT-1]) resp1_result <= rop_result;
    end
  end

  assign idle = ~(|tag_v) & ~resp0_valid & ~resp1_valid;

endmodule

// File: doc/rop3_arbiter.md
Name: rop3_arbiter

Overview:
- Shares one ROP3 raster-operation core (rop3_lut256 or rop3_smart, LAT-cycle registered latency) between two requesters.
- Arbitrates per beat using round-robin with a bounded burst. Drives the core operands from an issue register.
- Tracks in-flight beats through a tag pipeline and routes each Result back to its owning requester.
- Sits between the pixel-fetch engines and the ROP3 core in the blit path.

Parameters:
- N, 8: pixel width of P/S/D/Result.
- LAT, 2: core latency, counted from the issue-register edge to a valid rop_result.
- MAX_BURST, 4: maximum consecutive accepted beats from one requester while the other is waiting.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 beat valid
- req0_ready  output  1  requester 0 beat accepted (combinational)
- req0_P / req0_S / req0_D  input  N each  pattern / source / destination operands
- req0_mode  input  8  ROP3 code
- req1_valid, req1_ready, req1_P, req1_S, req1_D, req1_mode: same as requester 0, for requester 1
- resp0_valid  output  1  result valid for requester 0 (one-cycle pulse per beat)
- resp0_result  output  N  result for requester 0
- resp1_valid, resp1_result  output  1, N  same, for requester 1
- rop_P / rop_S / rop_D  output  N each  to core, registered
- rop_mode  output  8  to core, registered
- rop_result  input  N  from core
- idle  output  1  high when no beat is in flight and no response is pending

Behaviour:
- Reset values: rop_P/S/D/mode = 0; resp*_valid = 0; resp*_result = 0; tag pipeline cleared; owner = 1; burst_cnt = MAX_BURST; idle = 1. The ready outputs are forced to 0 while rst_n is low.
- Grant, combinational, at most one ready high per cycle:
  - Only reqX valid: grant X.
  - Both valid and burst_cnt < MAX_BURST: grant owner.
  - Both valid and burst_cnt == MAX_BURST: grant the other requester.
  - Neither valid: no grant.
  - The reset values make the first tie go to req0.
- Fire = valid & ready. State update per edge:
  - Owner fires: burst_cnt = min(burst_cnt+1, MAX_BURST).
  - Other requester fires: owner = that requester; burst_cnt = 1.
  - No fire: owner and burst_cnt hold. A burst resumes after an idle gap.
- Issue: on a fire edge, rop_* capture the granted operands and tag stage 0 = {1, id}. With no fire, rop_* hold their values and tag stage 0 valid = 0.
- The tag pipeline is LAT stages deep. The final stage aligns with rop_result.
- Response: one edge after a tag reaches the final stage, respX_valid = 1 for id X, and respX_result = rop_result. The other respX_valid = 0. respX_result holds its value when not valid.
- Latency: a fire in cycle t produces respX_valid high in cycle t+LAT+1 (t+3 at default).
- Throughput is 1 beat per cycle. Results per requester return in acceptance order. No response backpressure: requesters always accept.
- Requester rules, checked by the bench: valid must not depend on ready; operands must hold while valid & !ready.
- idle = no valid tag in any stage and both resp*_valid low.
- Reset mid-operation: all in-flight beats are discarded. No response is emitted for them after release.
- Mode and operands pass through unmodified. The arbiter performs no arithmetic.

Test Plan:
1. Reset: hold rst_n = 0 with both valids high -> ready = 0, rop_* = 0, resp*_valid = 0, idle = 1. Release -> first tie grants req0.
2. Single stream on req0: 8 back-to-back beats, P=8'hF0, S=8'hCC, D=8'hAA, mode=8'h96 -> resp0_valid high for 8 consecutive cycles starting at t+3, each result 8'h96. resp1_valid stays 0.
3. Same stream with mode=8'hCC then 8'hF0 alternating -> results alternate 8'hCC, 8'hF0 in order. rop_mode matches the issue order.
4. Both requesters valid continuously, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,... Each response is routed to the correct resp port with the correct ordering.
5. req0 stream with a 2-cycle valid gap after beat 2 while req1 idle, then req1 rises -> req0 keeps ownership. req0 grants continue until burst_cnt reaches 4, then req1 is granted.
6. Three beats in flight, assert rst_n = 0 for one cycle -> no resp*_valid pulses afterward. idle = 1. The next accepted beat returns correctly at t+3.
